trial_div_factor: RTL
=====================

// Module: trial_div_factor
// PURPOSE
//  Sequential prime-factorisation engine; sits directly downstream of the digit-entry
//  stage (INPUT). Takes the six BCD digits the user entered plus a start pulse,
//  converts them to binary, factorises by trial division with a serial restoring
//  divider, and streams the prime factors out in ascending order, with multiplicity,
//  over a valid/ack handshake to the display/result stage.
// PARAMETERS
//  WIDTH   20  binary datapath width for N, divisor, quotient and remainder; >=20 so 999999 fits
//  CNT_W    5  width of the factor counter; max 19 factors, since 2^19 < 10^6 < 2^20
// PORTS
//  CLK         in   1      system clock, all logic on rising edge
//  RST         in   1      synchronous reset, active-high
//  START       in   1      one-cycle request; ignored unless state==IDLE
//  DIN1..DIN6  in   4 each BCD digits; DIN1=ones .. DIN6=hundred-thousands (SEG1..SEG6 of INPUT)
//  BUSY        out  1      high in every state except IDLE
//  FACT        out  WIDTH  current prime factor; valid only while FACT_VALID=1
//  FACT_VALID  out  1      factor offered; held, with FACT stable, until accepted
//  FACT_ACK    in   1      consumer accept; transfer occurs on a cycle with VALID&ACK both 1
//  COUNT       out  CNT_W  number of factors transferred since the last START
//  DONE        out  1      one-cycle pulse at end of every run (normal or error)
//  ERR         out  1      sticky from DONE until next accepted START: bad digit or N<2
// BEHAVIOUR
//  Reset: state=IDLE; BUSY, FACT, FACT_VALID, COUNT, DONE, ERR all 0. RST overrides
//   everything incl. mid-run; the run is abandoned, no DONE.
//  FSM: IDLE -> LOAD -> CONV -> DIV -> CHECK -> {EMIT|DIV|FIN} ; FIN -> IDLE.
//  IDLE: START=1 -> latch DIN1..6, clear COUNT and ERR, go LOAD. BUSY rises next cycle.
//  LOAD (1 cyc): any digit >9 -> ERR=1, go FIN. Else go CONV.
//  CONV (6 cyc): N = N*10 + digit, DIN6 first, DIN1 last (N*10 as (N<<3)+(N<<1)).
//   Then if N<2 -> ERR=1, go FIN; else d=2, go DIV.
//  DIV (WIDTH cyc): restoring division, one quotient bit per cycle, MSB first; yields q=N/d, r=N%d.
//  CHECK (1 cyc), priority order:
//   r==0       -> FACT=d, N=q, go EMIT (d unchanged; repeats factor)
//   q<d        -> (d*d>N, N prime) FACT=N, N=1, go EMIT
//   otherwise  -> d = (d==2) ? 3 : d+2, go DIV
//  EMIT: FACT_VALID=1. On VALID&ACK: VALID=0, COUNT+=1; then N==1 -> FIN, else -> DIV.
//   FACT/VALID must not change while waiting. ACK while VALID=0 is ignored.
//  FIN (1 cyc): DONE=1 for exactly this cycle, go IDLE. ERR runs emit no factor.
//  START while BUSY=1: ignored, no effect on the run or latched digits.
//  DIN changes after START: no effect until next accepted START.
//  COUNT and the last FACT value hold after DONE until next START/RST.
//  Worst case per divisor attempt: WIDTH+1 cycles, plus handshake wait.
// TESTING
//  1 DIN=000012, ACK tied 1 -> FACT 2,2,3 in order; COUNT=3; one DONE pulse; ERR=0
//  2 DIN=999983 (prime) -> exactly one transfer FACT=999983; COUNT=1; ERR=0
//  3 DIN=000001, then DIN=000000 -> no FACT_VALID, DONE pulse, ERR=1, COUNT=0 each run
//  4 DIN3=4'hA, other digits 0 -> ERR=1, DONE within 3 cycles of START, no factors
//  5 DIN=524288 (2^19), ACK held 0 for 5 cyc on 3rd factor -> FACT=2 and VALID stable
//    while waiting; 19 transfers of 2; COUNT=19
//  6 DIN=000030; pulse START again during DIV -> ignored, FACT 2,3,5; then RST mid-DIV on
//    a new run -> all outputs 0 next cycle, no DONE; fresh START then completes normally

Source files
------------

// File: rtl/trial_div_factor.sv
// trial_div_factor: BCD-to-binary conversion and trial-division
// prime factoriser streaming factors over a valid/ack handshake.
module trial_div_factor #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       DIN1,
  input  logic [3:0]       DIN2,
  input  logic [3:0]       DIN3,
  input  logic [3:0]       DIN4,
  input  logic [3:0]       DIN5,
  input  logic [3:0]       DIN6,
  output logic             BUSY,
  output logic [WIDTH-1:0] FACT,
  output logic             FACT_VALID,
  input  logic             FACT_ACK,
  output logic [CNT_W-1:0] COUNT,
  output logic             DONE,
  output logic             ERR
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CONV, DIV, CHECK, EMIT, FIN
  } state_t;

  state_t state, nxt;

  logic [5:0][3:0]  dig;
  logic [WIDTH-1:0] n, d, q, r;
  logic [BW-1:0]    step;
  logic [3:0]       cur;
  logic [WIDTH-1:0] n10;
  logic             bad;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             last_conv;
  logic             last_div;
  logic             xfer;

  assign BUSY       = (state != IDLE);
  assign FACT_VALID = (state == EMIT);
  assign DONE       = (state == FIN);
  assign xfer       = FACT_VALID & FACT_ACK;
  assign last_conv  = (step == BW'(5));
  assign last_div   = (step == BW'(WIDTH - 1));

  // Pick the digit for this conversion step, most significant first.
  always_comb begin
    cur = '0;
    unique case (step)
      BW'(0):  cur = dig[5];
      BW'(1):  cur = dig[4];
      BW'(2):  cur = dig[3];
      BW'(3):  cur = dig[2];
      BW'(4):  cur = dig[1];
      BW'(5):  cur = dig[0];
      default: cur = '0;
    endcase
  end

  // Shared arithmetic: N*10+digit, digit range check, divider step.
  always_comb begin
    n10 = (n << 3) + (n << 1) + {{(WIDTH-4){1'b0}}, cur};
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (dig[i] > 4'd9) bad = 1'b1;
    end
    sh   = {r, q[WIDTH-1]};
    ge   = (sh >= {1'b0, d});
    diff = sh[WIDTH-1:0] - d;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (START) nxt = LOAD;
      LOAD:  nxt = bad ? FIN : CONV;
      CONV:  if (last_conv)
               nxt = (n10 < WIDTH'(2)) ? FIN : DIV;
      DIV:   if (last_div) nxt = CHECK;
      CHECK: nxt = (r == '0 || q < d) ? EMIT : DIV;
      EMIT:  if (xfer)
               nxt = (n == WIDTH'(1)) ? FIN : DIV;
      FIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: digit latch, conversion, division, factor and count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dig   <= '0;
      n     <= '0;
      d     <= '0;
      q     <= '0;
      r     <= '0;
      step  <= '0;
      FACT  <= '0;
      COUNT <= '0;
      ERR   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (START) begin
          dig   <= {DIN6, DIN5, DIN4, DIN3, DIN2, DIN1};
          COUNT <= '0;
          ERR   <= 1'b0;
        end
        LOAD: begin
          n    <= '0;
          step <= '0;
          if (bad) ERR <= 1'b1;
        end
        CONV: begin
          n    <= n10;
          step <= step + BW'(1);
          if (last_conv) begin
            if (n10 < WIDTH'(2)) begin
              ERR <= 1'b1;
            end else begin
              d    <= WIDTH'(2);
              q    <= n10;
              r    <= '0;
              step <= '0;
            end
          end
        end
        DIV: begin
          q    <= {q[WIDTH-2:0], ge};
          r    <= ge ? diff : sh[WIDTH-1:0];
          step <= step + BW'(1);
        end
        CHECK: begin
          if (r == '0) begin
            FACT <= d;
            n    <= q;
          end else if (q < d) begin
            FACT <= n;
            n    <= WIDTH'(1);
          end else begin
            d    <= (d == WIDTH'(2)) ? WIDTH'(3)
                                     : d + WIDTH'(2);
            q    <= n;
            r    <= '0;
            step <= '0;
          end
        end
        EMIT: if (xfer) begin
          COUNT <= COUNT + CNT_W'(1);
          q     <= n;
          r     <= '0;
          step  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
